// File: rtl/conv_25d_sequencer.sv
// Frame-level sequencer for one convolution_25D layer: kernel load, raster pixel
// streaming under a datapath clock-enable, valid-window tagging, flush and output stream.
module conv_25d_sequencer #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5,
    parameter int Z_DEPTH   = 3,
    parameter int NUM_TREES = 4,
    parameter int PIPE_LAT  = 8,
    parameter int KBYTES    = NUM_TREES * K * K * Z_DEPTH,
    parameter int KW        = (KBYTES > 1) ? $clog2(KBYTES) : 1,
    parameter int RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    parameter int CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          load_kernel,
    input  logic          k_valid,
    output logic          k_ready,
    input  logic [7:0]    k_data,
    output logic          kernel_we,
    output logic [KW-1:0] kernel_addr,
    output logic [7:0]    kernel_wdata,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          conv_advance,
    output logic          conv_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done
);

    localparam int FW = $clog2(PIPE_LAT + 1);
    localparam logic [KW-1:0] K_LAST   = KW'(KBYTES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
    localparam logic [CW-1:0] COL_K    = CW'(K - 1);
    localparam logic [FW-1:0] FL_MAX   = FW'(PIPE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t state_q, state_d;
    logic [KW-1:0] kcnt_q, kcnt_d, kernel_addr_q, kernel_addr_d;
    logic [7:0]    kernel_wdata_q, kernel_wdata_d;
    logic          kernel_we_q, kernel_we_d, frame_done_q, frame_done_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [PIPE_LAT-1:0]         tag_pipe_q, tag_pipe_d;
    logic [PIPE_LAT-1:0][RW-1:0] row_pipe_q, row_pipe_d;
    logic [PIPE_LAT-1:0][CW-1:0] col_pipe_q, col_pipe_d;
    // Set when the tail result was handed downstream while the datapath stood still.
    logic          taken_q, taken_d;
    logic          stall_s, pix_acc_s;

    assign out_valid    = tag_pipe_q[PIPE_LAT-1] & ~taken_q;
    assign out_row      = row_pipe_q[PIPE_LAT-1];
    assign out_col      = col_pipe_q[PIPE_LAT-1];
    assign stall_s      = out_valid & ~out_ready;
    assign pix_ready    = (state_q == S_RUN) & ~stall_s;
    assign pix_acc_s    = pix_valid & pix_ready;
    assign conv_advance = ~stall_s & (pix_acc_s | ((state_q == S_DRAIN) & (flush_q < FL_MAX)));
    assign conv_zero    = (state_q == S_DRAIN);
    assign k_ready      = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign kernel_we    = kernel_we_q;
    assign kernel_addr  = kernel_addr_q;
    assign kernel_wdata = kernel_wdata_q;
    assign frame_done   = frame_done_q;

    // Next-state, counter and tag-pipe computation.
    always_comb begin
        state_d        = state_q;
        kcnt_d         = kcnt_q;
        kernel_we_d    = 1'b0;
        kernel_addr_d  = kernel_addr_q;
        kernel_wdata_d = kernel_wdata_q;
        row_d          = row_q;
        col_d          = col_q;
        flush_d        = flush_q;
        frame_done_d   = 1'b0;
        tag_pipe_d     = tag_pipe_q;
        row_pipe_d     = row_pipe_q;
        col_pipe_d     = col_pipe_q;
        taken_d        = taken_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kcnt_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    flush_d = '0;
                    state_d = load_kernel ? S_LOAD : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (k_valid) begin
                    kernel_we_d    = 1'b1;
                    kernel_addr_d  = kcnt_q;
                    kernel_wdata_d = k_data;
                    kcnt_d         = kcnt_q + KW'(1);
                    state_d        = (kcnt_q == K_LAST) ? S_RUN : S_LOAD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (pix_acc_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    state_d = ((row_q == ROW_LAST) && (col_q == COL_LAST)) ? S_DRAIN : S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (conv_advance) begin
                    flush_d = flush_q + FW'(1);
                end else begin
                    flush_d = flush_q;
                end
                if ((flush_q == FL_MAX) && !out_valid) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Tag travels with the window's top-left coordinate; flush bubbles carry tag 0.
        if (conv_advance) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_pipe_d[i] = tag_pipe_q[i-1];
                row_pipe_d[i] = row_pipe_q[i-1];
                col_pipe_d[i] = col_pipe_q[i-1];
            end
            tag_pipe_d[0] = (state_q == S_RUN) & (row_q >= ROW_K) & (col_q >= COL_K);
            row_pipe_d[0] = row_q - ROW_K;
            col_pipe_d[0] = col_q - COL_K;
            taken_d       = 1'b0;
        end else if (out_valid && out_ready) begin
            taken_d = 1'b1;
        end else begin
            taken_d = taken_q;
        end
    end

    // State and datapath-control registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            kcnt_q         <= '0;
            kernel_we_q    <= 1'b0;
            kernel_addr_q  <= '0;
            kernel_wdata_q <= 8'd0;
            row_q          <= '0;
            col_q          <= '0;
            flush_q        <= '0;
            frame_done_q   <= 1'b0;
            tag_pipe_q     <= '0;
            row_pipe_q     <= '0;
            col_pipe_q     <= '0;
            taken_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            kcnt_q         <= kcnt_d;
            kernel_we_q    <= kernel_we_d;
            kernel_addr_q  <= kernel_addr_d;
            kernel_wdata_q <= kernel_wdata_d;
            row_q          <= row_d;
            col_q          <= col_d;
            flush_q        <= flush_d;
            frame_done_q   <= frame_done_d;
            tag_pipe_q     <= tag_pipe_d;
            row_pipe_q     <= row_pipe_d;
            col_pipe_q     <= col_pipe_d;
            taken_q        <= taken_d;
        end
    end

endmodule

// File: tb/tb_conv_25d_sequencer.sv
// Self-checking bench for conv_25d_sequencer: table of frame scenarios against a
// raster/queue reference model, plus hand-written reset and idle sequences.
module tb_conv_25d_sequencer;

    localparam int W = 8, H = 8, K = 3, Z = 2, T = 2, PL = 8;
    localparam int KB   = T * K * K * Z;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - K + 1) * (H - K + 1);
    localparam int KW = $clog2(KB), RW = $clog2(H), CW = $clog2(W);

    logic          clock, reset, start, load_kernel, k_valid, k_ready;
    logic [7:0]    k_data, kernel_wdata;
    logic          kernel_we, pix_valid, pix_ready, conv_advance, conv_zero;
    logic [KW-1:0] kernel_addr;
    logic          out_valid, out_ready, busy, frame_done;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    conv_25d_sequencer #(.IMG_W(W), .IMG_H(H), .K(K), .Z_DEPTH(Z), .NUM_TREES(T), .PIPE_LAT(PL)) dut (
        .clock(clock), .reset(reset), .start(start), .load_kernel(load_kernel),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .kernel_we(kernel_we), .kernel_addr(kernel_addr), .kernel_wdata(kernel_wdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .conv_advance(conv_advance),
        .conv_zero(conv_zero), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit ld;
        int pv_pct;
        int or_mode;     // 0 always ready, 1 toggling 1010.., 2 random
        bit mid_start;
        int exp_outs;
        int exp_kw;
    } vec_t;

    vec_t tbl[5];
    int   n_tests, n_fail;
    int   exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int all_outs();
        return int'({k_ready, kernel_we, kernel_addr, kernel_wdata, pix_ready, conv_advance,
                     conv_zero, out_valid, out_row, out_col, busy, frame_done});
    endfunction

    task automatic run_frame(input vec_t v, input int abort_at);
        int kb_sent, kw, pix_n, outs, adv_drain, acc22, first_out, r, c, e;
        bit done, running, stall, draining, aborted;
        kb_sent = 0; kw = 0; pix_n = 0; outs = 0; adv_drain = 0;
        acc22 = -1; first_out = -1; done = 0; aborted = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clock);
            start       = (cyc == 0) || (v.mid_start && cyc == 30);
            load_kernel = (cyc == 0) ? v.ld : v.mid_start;
            k_valid     = ($urandom_range(99) < 70);
            k_data      = 8'(kb_sent);
            pix_valid   = ($urandom_range(99) < v.pv_pct);
            case (v.or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(1) == 1);
            endcase
            #1;
            running  = (cyc >= 1) && (!v.ld || kb_sent == KB) && (pix_n < NPIX);
            stall    = out_valid && !out_ready;
            draining = (pix_n == NPIX);
            chk("k_ready", int'(k_ready), int'(v.ld && cyc >= 1 && kb_sent < KB));
            chk("pix_ready", int'(pix_ready), int'(running && !stall));
            chk("conv_zero", int'(conv_zero), int'(draining && !frame_done));
            if (!draining) chk("conv_advance_run", int'(conv_advance), int'(pix_valid && pix_ready));
            if (stall) chk("conv_advance_stall", int'(conv_advance), 0);
            if (out_valid) chk("out_valid_has_window", int'(exp_q.size() > 0), 1);
            if (kernel_we) begin
                chk("kernel_addr", int'(kernel_addr), kw);
                chk("kernel_wdata", int'(kernel_wdata), kw);
                kw++;
            end
            if (k_valid && k_ready) kb_sent++;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_row", int'(out_row), e / 256);
                    chk("out_col", int'(out_col), e % 256);
                end
                outs++;
            end
            if (pix_valid && pix_ready) begin
                r = pix_n / W;
                c = pix_n % W;
                if (r == K - 1 && c == K - 1) acc22 = cyc;
                if (r >= K - 1 && c >= K - 1) exp_q.push_back((r - K + 1) * 256 + (c - K + 1));
                pix_n++;
            end
            if (draining && conv_advance) adv_drain++;
            if (frame_done) begin
                chk("busy_at_done", int'(busy), 0);
                done = 1;
            end
            if (abort_at >= 0 && pix_n == abort_at) begin
                aborted = 1;
                done = 1;
            end
        end
        if (!aborted) begin
            chk("frame_completed", int'(done), 1);
            chk("out_count", outs, v.exp_outs);
            chk("kernel_writes", kw, v.exp_kw);
            chk("pixels_taken", pix_n, NPIX);
            chk("flush_advances", adv_drain, PL);
            chk("model_queue_empty", exp_q.size(), 0);
            if (v.or_mode == 0 && v.pv_pct == 100 && acc22 >= 0)
                chk("first_out_latency", first_out - acc22, PL);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; load_kernel = 1'b0; k_valid = 1'b0; k_data = 8'd0;
        pix_valid = 1'b0; out_ready = 1'b0;
        tbl[0] = '{ld: 1'b1, pv_pct: 100, or_mode: 0, mid_start: 1'b0, exp_outs: NOUT, exp_kw: KB};
        tbl[1] = '{ld: 1'b0, pv_pct: 100, or_mode: 1, mid_start: 1'b0, exp_outs: NOUT, exp_kw: 0};
        tbl[2] = '{ld: 1'b0, pv_pct: 50,  or_mode: 0, mid_start: 1'b0, exp_outs: NOUT, exp_kw: 0};
        tbl[3] = '{ld: 1'b0, pv_pct: 60,  or_mode: 2, mid_start: 1'b1, exp_outs: NOUT, exp_kw: 0};
        tbl[4] = '{ld: 1'b1, pv_pct: 70,  or_mode: 2, mid_start: 1'b1, exp_outs: NOUT, exp_kw: KB};

        repeat (3) @(negedge clock);
        #1 chk("reset_outputs_zero", all_outs(), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(tbl[i], -1);

        // Abort a frame with a one-cycle reset after 20 accepted pixels.
        run_frame(tbl[2], 20);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0;
        #1 chk("midframe_reset_zero", all_outs(), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            chk("no_done_after_abort", int'(frame_done), 0);
            chk("idle_after_abort", int'(busy), 0);
        end
        run_frame(tbl[1], -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
